// File: rtl/tcp_test_gen_if.sv
// rtl/tcp_test_gen_if.sv - byte write port toward the SiTCP TCP TX FIFO
interface tcp_test_gen_if;
   logic       tx_wr;
   logic [7:0] tx_data;
   logic       tx_full;

   modport master (output tx_wr, output tx_data, input tx_full);
   modport slave  (input tx_wr, input tx_data, output tx_full);
endinterface

// File: rtl/tcp_test_gen.sv
// rtl/tcp_test_gen.sv - SiTCP TX test-data generator: counter/pattern bytes with rate, blocks and error injection
module tcp_test_gen #(
   parameter logic [7:0] ERR_MASK = 8'h01,
   parameter int         GAP_W    = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_data_gen,
   input  logic [63:0]      i_num_of_data,
   input  logic [GAP_W-1:0] i_tx_rate,
   input  logic [2:0]       i_word_len,
   input  logic             i_select_seq,
   input  logic [31:0]      i_seq_pattern,
   input  logic [23:0]      i_blk_size,
   input  logic             i_ins_error_trigger,
   tcp_test_gen_if.master   tx,
   output logic             o_busy,
   output logic             o_done
);
   typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

   state_t           state;
   logic             data_gen_q;
   logic             trig_q;
   logic             err_armed;
   logic [63:0]      num_q;
   logic [GAP_W-1:0] rate_q;
   logic [GAP_W-1:0] gap_cnt;
   logic [2:0]       wl_q;
   logic             sel_q;
   logic [31:0]      pat_q;
   logic [23:0]      blk_q;
   logic [63:0]      byte_cnt;
   logic [63:0]      word_cnt;
   logic [2:0]       byte_idx;
   logic [1:0]       pat_idx;
   logic [23:0]      blk_cnt;
   logic             tx_wr_q;
   logic [7:0]       tx_data_q;

   logic             issue;
   logic             last_byte;
   logic             blk_end;
   logic             word_end;
   logic             trig_rise;
   logic [63:0]      word_shifted;
   logic [31:0]      pat_shifted;
   logic [7:0]       cur_byte;

   assign trig_rise    = i_ins_error_trigger & ~trig_q;
   assign issue        = (state == RUN) & i_data_gen & ~tx.tx_full;
   assign last_byte    = (num_q != 64'd0) && (byte_cnt + 64'd1 == num_q);
   assign blk_end      = (blk_q != 24'd0) && (blk_cnt + 24'd1 == blk_q);
   assign word_end     = (byte_idx == wl_q);
   // Big-endian within the word: byte 0 of a word is its most significant used byte
   assign word_shifted = word_cnt >> {(wl_q - byte_idx), 3'b000};
   assign pat_shifted  = pat_q >> {~pat_idx, 3'b000};
   assign cur_byte     = sel_q ? pat_shifted[7:0] : word_shifted[7:0];

   assign tx.tx_wr   = tx_wr_q;
   assign tx.tx_data = tx_data_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         data_gen_q <= 1'b0;
         trig_q     <= 1'b0;
         err_armed  <= 1'b0;
         num_q      <= '0;
         rate_q     <= '0;
         gap_cnt    <= '0;
         wl_q       <= '0;
         sel_q      <= 1'b0;
         pat_q      <= '0;
         blk_q      <= '0;
         byte_cnt   <= '0;
         word_cnt   <= '0;
         byte_idx   <= '0;
         pat_idx    <= '0;
         blk_cnt    <= '0;
         tx_wr_q    <= 1'b0;
         tx_data_q  <= 8'h00;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         data_gen_q <= i_data_gen;
         trig_q     <= i_ins_error_trigger;
         tx_wr_q    <= 1'b0;
         o_done     <= 1'b0;
         // A new edge wins over consumption so a coincident request is not lost
         if (trig_rise)
            err_armed <= 1'b1;
         else if (issue)
            err_armed <= 1'b0;

         case (state)
            IDLE: begin
               if (i_data_gen && !data_gen_q) begin
                  num_q    <= i_num_of_data;
                  rate_q   <= i_tx_rate;
                  wl_q     <= i_word_len;
                  sel_q    <= i_select_seq;
                  pat_q    <= i_seq_pattern;
                  blk_q    <= i_blk_size;
                  byte_cnt <= '0;
                  word_cnt <= '0;
                  byte_idx <= '0;
                  pat_idx  <= '0;
                  blk_cnt  <= '0;
                  state    <= RUN;
                  o_busy   <= 1'b1;
               end
            end
            RUN: begin
               if (!i_data_gen) begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end else if (issue) begin
                  tx_wr_q   <= 1'b1;
                  tx_data_q <= cur_byte ^ (err_armed ? ERR_MASK : 8'h00);
                  byte_cnt  <= byte_cnt + 64'd1;
                  if (blk_end) begin
                     word_cnt <= '0;
                     byte_idx <= '0;
                     pat_idx  <= '0;
                     blk_cnt  <= '0;
                  end else begin
                     blk_cnt <= blk_cnt + 24'd1;
                     pat_idx <= pat_idx + 2'd1;
                     if (word_end) begin
                        byte_idx <= '0;
                        word_cnt <= word_cnt + 64'd1;
                     end else begin
                        byte_idx <= byte_idx + 3'd1;
                     end
                  end
                  if (last_byte) begin
                     state  <= DONE;
                     o_done <= 1'b1;
                     o_busy <= 1'b0;
                  end else if (rate_q != '0) begin
                     state   <= GAP;
                     gap_cnt <= rate_q;
                  end
               end
            end
            GAP: begin
               if (!i_data_gen) begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end else if (gap_cnt == GAP_W'(1)) begin
                  state <= RUN;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            DONE: begin
               if (!i_data_gen)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tcp_test_gen.sv
// tb/tb_tcp_test_gen.sv - randomized self-checking bench for tcp_test_gen against a byte-index model
module tb_tcp_test_gen;
   localparam logic [7:0] MASK = 8'h01;

   logic        clk;
   logic        rst_n;
   logic        data_gen;
   logic [63:0] num_of_data;
   logic [7:0]  tx_rate;
   logic [2:0]  word_len;
   logic        select_seq;
   logic [31:0] seq_pattern;
   logic [23:0] blk_size;
   logic        ins_err;
   logic        tx_full;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int arm_q[$];

   tcp_test_gen_if tx();
   assign tx.tx_full = tx_full;

   tcp_test_gen #(.ERR_MASK(MASK), .GAP_W(8)) dut (
      .i_clk               (clk),
      .i_rst_n             (rst_n),
      .i_data_gen          (data_gen),
      .i_num_of_data       (num_of_data),
      .i_tx_rate           (tx_rate),
      .i_word_len          (word_len),
      .i_select_seq        (select_seq),
      .i_seq_pattern       (seq_pattern),
      .i_blk_size          (blk_size),
      .i_ins_error_trigger (ins_err),
      .tx                  (tx.master),
      .o_busy              (busy),
      .o_done              (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   // Byte number idx of a run, derived from the stream definition alone
   function automatic logic [7:0] model_byte(input longint unsigned idx, input logic [2:0] wl,
                                             input logic sel, input logic [31:0] pat,
                                             input logic [23:0] blk);
      longint unsigned pos, bpw, word, k;
      logic [63:0] t64;
      logic [31:0] t32;
      pos = (blk != 0) ? idx % longint'(blk) : idx;
      if (sel) begin
         t32 = pat >> (8 * (3 - (pos % 4)));
         return t32[7:0];
      end
      bpw  = longint'(wl) + 1;
      word = pos / bpw;
      k    = pos % bpw;
      t64  = word >> (8 * (bpw - 1 - k));
      return t64[7:0];
   endfunction

   task automatic run_case(input logic [63:0] num, input logic [7:0] rate, input logic [2:0] wl,
                           input logic sel, input logic [31:0] pat, input logic [23:0] blk,
                           input int full_pct, input int trig_after, input int hold_at,
                           input int stop_after, input bit start_high);
      int got, done_cnt, last_wr, start_cyc, hold_left, extra;
      bit finished, hit;
      logic [7:0] exp_b;
      got = 0; done_cnt = 0; last_wr = 0; hold_left = 0; extra = 0; finished = 0;
      num_of_data = num; tx_rate = rate; word_len = wl; select_seq = sel;
      seq_pattern = pat; blk_size = blk; tx_full = 1'b0;
      if (trig_after == -2) begin
         ins_err = 1'b1;
         arm_q.push_back(cyc + 2);
         tick();
         ins_err = 1'b0;
      end
      if (!start_high) data_gen = 1'b1;
      start_cyc = cyc;
      for (int n = 0; n < 2000 && !finished; n++) begin
         tick();
         if (ins_err) ins_err = 1'b0;
         if (tx.tx_wr) begin
            exp_b = model_byte(longint'(got), wl, sel, pat, blk);
            hit = 0;
            while (arm_q.size() > 0 && arm_q[0] <= cyc) begin
               void'(arm_q.pop_front());
               hit = 1;
            end
            if (hit) exp_b = exp_b ^ MASK;
            check_eq("byte", tx.tx_data, exp_b);
            check_eq("wr_while_full", tx_full, 1'b0);
            if (full_pct == 0 && hold_at < 0) begin
               if (got == 0) check_eq("first_lat", cyc - start_cyc, 2);
               else          check_eq("spacing", cyc - last_wr, rate + 1);
            end
            last_wr = cyc;
            got++;
            check_eq("done_align", done, (num != 0 && got == num));
            check_eq("busy", busy, !(num != 0 && got == num));
            if (done) done_cnt++;
            if (trig_after == got - 1) begin
               ins_err = 1'b1;
               arm_q.push_back(cyc + 2);
            end
            if (num != 0 && got == num) finished = 1;
            if (num == 0 && got == stop_after) begin
               data_gen = 1'b0;
               finished = 1;
            end
            if (got == hold_at + 1) hold_left = 10;
         end else if (done) begin
            check_eq("done_nowr", done, 1'b0);
         end
         if (hold_left > 0) begin
            tx_full = 1'b1;
            hold_left--;
         end else begin
            tx_full = (full_pct > 0) && ($urandom_range(99) < full_pct);
         end
      end
      tx_full = 1'b0;
      // data_gen stays high here for finite runs: DONE must hold without restarting
      repeat (4) begin
         tick();
         if (ins_err) ins_err = 1'b0;
         if (tx.tx_wr) extra++;
         if (done) extra++;
      end
      check_eq("no_extra", extra, 0);
      check_eq("busy_end", busy, 1'b0);
      check_eq("count", got, (num == 0) ? 64'(stop_after) : num);
      check_eq("done_cnt", done_cnt, (num != 0) ? 1 : 0);
      data_gen = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      logic [63:0] r_num;
      logic [7:0]  r_rate;
      logic [2:0]  r_wl;
      logic        r_sel;
      logic [31:0] r_pat;
      logic [23:0] r_blk;
      int          r_full, r_trig;

      rst_n = 1'b0; data_gen = 1'b0; num_of_data = '0; tx_rate = '0; word_len = '0;
      select_seq = 1'b0; seq_pattern = '0; blk_size = '0; ins_err = 1'b0; tx_full = 1'b0;
      tick();
      tick();
      check_eq("rst_wr", tx.tx_wr, 1'b0);
      check_eq("rst_data", tx.tx_data, 8'h00);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      rst_n = 1'b1;
      tick();

      run_case(6,  0, 1, 0, 32'h0,        0, 0, -1, -1, 0, 0);
      run_case(5,  0, 0, 1, 32'hA1B2C3D4, 0, 0, -1, -1, 0, 0);
      run_case(3,  2, 0, 0, 32'h0,        0, 0, -1, -1, 0, 0);
      run_case(10, 0, 0, 0, 32'h0,        0, 0, -1,  3, 0, 0);
      run_case(10, 0, 0, 0, 32'h0,        4, 0, -1, -1, 0, 0);
      run_case(7,  0, 0, 0, 32'h0,        0, 0,  2, -1, 0, 0);
      run_case(4,  1, 2, 0, 32'h0,        0, 0, -2, -1, 0, 0);
      run_case(0,  0, 0, 0, 32'h0,        0, 25, -1, -1, 12, 0);
      run_case(0,  3, 1, 1, 32'h5A0FF0C3, 3, 0, -1, -1, 7, 0);

      for (int r = 0; r < 10; r++) begin
         r_num  = 64'($urandom_range(20, 1));
         r_rate = 8'($urandom_range(3));
         r_wl   = 3'($urandom_range(7));
         r_sel  = 1'($urandom_range(1));
         r_pat  = $urandom;
         r_blk  = ($urandom_range(1) == 1) ? 24'($urandom_range(9, 1)) : 24'd0;
         r_full = ($urandom_range(1) == 1) ? 30 : 0;
         r_trig = ($urandom_range(2) == 0) ? -1 : int'($urandom_range(int'(r_num) - 1));
         run_case(r_num, r_rate, r_wl, r_sel, r_pat, r_blk, r_full, r_trig, -1, 0, 0);
      end

      num_of_data = 64'd0; tx_rate = 8'd0; word_len = 3'd0; select_seq = 1'b0; blk_size = 24'd0;
      data_gen = 1'b1;
      repeat (5) tick();
      check_eq("pre_rst_wr", tx.tx_wr, 1'b1);
      rst_n = 1'b0;
      #1;
      check_eq("abort_wr", tx.tx_wr, 1'b0);
      check_eq("abort_busy", busy, 1'b0);
      check_eq("abort_data", tx.tx_data, 8'h00);
      arm_q.delete();
      repeat (3) begin
         tick();
         check_eq("rst_hold_wr", tx.tx_wr, 1'b0);
      end
      rst_n = 1'b1;
      run_case(4, 0, 0, 0, 32'h0, 0, 0, -1, -1, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
